trace_capture_buffer: RTL and testbench
=======================================

Name: trace_capture_buffer

Overview:
- Debug trace recorder for the 16-bit programmable processor.
- Consumes the processor's observation outputs: PC, IR and state, qualified by an instruction-fetch strobe.
- Stores them in a circular buffer and freezes when the halt instruction (16'h5000) is captured.
- A host or bench drains the buffer oldest-first through a request/valid read port, so the executed program can be checked in hardware rather than by waveform inspection.

Parameters:
- DEPTH, 16, number of trace entries held; must be a power of two.
- AW, 4, address width, log2(DEPTH).
- HALT_IR, 16'h5000, IR value that ends capture.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Arm  in  1  one-cycle pulse; clears the buffer and starts capture.
- Cap_Valid  in  1  the PC/IR/State inputs hold a new fetched instruction this cycle.
- PC_In  in  7  processor program counter.
- IR_In  in  16  processor instruction register.
- State_In  in  4  processor FSM state.
- Rd_Req  in  1  request the next (oldest) entry.
- Rd_Data  out  27  entry packed as {State[26:23], PC[22:16], IR[15:0]}.
- Rd_Valid  out  1  Rd_Data is valid; asserted for exactly one cycle per accepted request.
- Count  out  AW+1  number of unread entries, 0..DEPTH.
- Busy  out  1  FSM is in CAPTURE.
- Done  out  1  FSM is in DONE.
- Wrapped  out  1  at least one entry was overwritten during this capture.

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE.
  - Write and read pointers = 0.
  - Count = 0, Rd_Data = 0, Rd_Valid = 0, Busy = 0, Done = 0, Wrapped = 0.
  - Reset mid-capture or mid-readout discards all contents.
- States:
  - IDLE: Arm -> CAPTURE. All other inputs are ignored.
  - CAPTURE: on each rising edge with Cap_Valid=1, write {State_In, PC_In, IR_In} at wptr.
    - wptr increments modulo DEPTH.
    - If Count < DEPTH, Count increments.
    - Otherwise the oldest entry is overwritten: rptr increments, Count stays DEPTH, Wrapped is set.
    - If IR_In == HALT_IR on that write, the halt entry is stored, then -> DONE.
  - DONE: capture is frozen and Cap_Valid is ignored.
    - Rd_Req with Count > 0: on the next cycle Rd_Data = mem[rptr] and Rd_Valid = 1.
    - rptr increments and Count decrements on the same edge the request is sampled.
    - Rd_Req with Count == 0: ignored, Rd_Valid stays 0.
    - FSM stays in DONE after draining. Only Arm or Reset leaves DONE.
- Arm in any state: pointers and Count cleared, Wrapped cleared, Rd_Valid forced to 0, -> CAPTURE on the next edge.
- Arm and Cap_Valid in the same cycle: Arm wins; that sample is not stored.
- Rd_Req outside DONE: ignored.
- Back-to-back Rd_Req: one entry per cycle, Rd_Valid held high continuously.
- Rd_Data holds its last value when Rd_Valid = 0.
- Busy and Done are registered decodes of the state, never both 1.
- Memory is inferred RAM with a synchronous read; read latency is 1 cycle from Rd_Req to Rd_Valid.
- Count arithmetic is AW+1 bits wide, so DEPTH is representable without overflow.

Test Plan:
- Reset: assert Reset asynchronously between clock edges -> all outputs 0 immediately; after release, FSM in IDLE; Cap_Valid pulses change nothing (Count stays 0).
- Basic capture:
  - Stimulus: Arm, then 3 Cap_Valid pulses with PC = 00/01/02 and IR = 1234/2345/3456, then PC = 03 with IR = 5000.
  - Required: Done = 1, Count = 4, Wrapped = 0.
  - Four Rd_Req -> Rd_Data IR fields 1234, 2345, 3456, 5000 in that order, each with the correct PC/State; Count ends at 0.
- Wrap-around:
  - Stimulus: Arm, then 20 captures with PC = 0..19 (non-halt), then a halt at PC = 20.
  - Required: Count = 16, Wrapped = 1; the first read returns PC = 5, the last read returns PC = 20 with IR = 5000.
- Empty and illegal reads:
  - Rd_Req in IDLE or CAPTURE -> Rd_Valid = 0, Count unchanged.
  - Rd_Req after draining in DONE -> Rd_Valid = 0, Count = 0.
- Simultaneous events: Arm and Cap_Valid asserted together while in DONE with Count = 4 -> next cycle Busy = 1, Count = 0; the sample is not stored.
- Reset mid-capture: Reset after 5 captures -> Count = 0 and Busy = 0 at once; re-Arm and capture 2 entries plus halt -> Count = 3 with the correct contents.

Source files
------------

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: circular debug trace of processor fetches (PC/IR/state).
// Capture stops once the halt instruction is stored. The host then drains the
// entries oldest-first through a one-cycle-latency request/valid read port.
module trace_capture_buffer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter logic [15:0] HALT_IR = 16'h5000
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Arm,
  input  logic          Cap_Valid,
  input  logic [6:0]    PC_In,
  input  logic [15:0]   IR_In,
  input  logic [3:0]    State_In,
  input  logic          Rd_Req,
  output logic [26:0]   Rd_Data,
  output logic          Rd_Valid,
  output logic [AW:0]   Count,
  output logic          Busy,
  output logic          Done,
  output logic          Wrapped
);

  localparam int unsigned DW = 27;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            wr_en_c;
  logic            rd_en_c;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [DW-1:0]   mem [DEPTH];

  // Next-state decode plus the write/read enables; Arm overrides everything.
  always_comb begin
    state_nxt = state;
    wr_en_c   = 1'b0;
    rd_en_c   = 1'b0;
    if (Arm) begin
      state_nxt = S_CAPTURE;
    end else begin
      case (state)
        S_CAPTURE: begin
          if (Cap_Valid) begin
            wr_en_c = 1'b1;
            if (IR_In == HALT_IR) state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (Rd_Req && (Count != '0)) rd_en_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State register with registered Busy/Done decodes of the next state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_nxt;
      Busy  <= (state_nxt == S_CAPTURE);
      Done  <= (state_nxt == S_DONE);
    end
  end

  // Pointer, occupancy and wrap bookkeeping; a full buffer drops its oldest entry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wptr    <= '0;
      rptr    <= '0;
      Count   <= '0;
      Wrapped <= 1'b0;
    end else if (Arm) begin
      wptr    <= '0;
      rptr    <= '0;
      Count   <= '0;
      Wrapped <= 1'b0;
    end else if (wr_en_c) begin
      wptr <= wptr + AW'(1);
      if (Count < FULL) begin
        Count <= Count + (AW+1)'(1);
      end else begin
        rptr    <= rptr + AW'(1);
        Wrapped <= 1'b1;
      end
    end else if (rd_en_c) begin
      rptr  <= rptr + AW'(1);
      Count <= Count - (AW+1)'(1);
    end
  end

  // Trace RAM write port (no reset, so it maps onto a RAM macro).
  always_ff @(posedge Clk) begin
    if (wr_en_c) mem[wptr] <= {State_In, PC_In, IR_In};
  end

  // Synchronous read port; Rd_Data holds its last value between reads.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Rd_Data  <= '0;
      Rd_Valid <= 1'b0;
    end else begin
      Rd_Valid <= rd_en_c;
      if (rd_en_c) Rd_Data <= mem[rptr];
    end
  end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Bench for trace_capture_buffer: directed scenarios plus randomized sessions,
// all checked against a queue-based model of the trace buffer.
module tb_trace_capture_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam logic [15:0] HALT  = 16'h5000;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Arm = 1'b0;
  logic          Cap_Valid = 1'b0;
  logic [6:0]    PC_In = '0;
  logic [15:0]   IR_In = '0;
  logic [3:0]    State_In = '0;
  logic          Rd_Req = 1'b0;
  logic [26:0]   Rd_Data;
  logic          Rd_Valid;
  logic [AW:0]   Count;
  logic          Busy;
  logic          Done;
  logic          Wrapped;

  int checks = 0;
  int errors = 0;

  // Reference model: entries held oldest-first; mode 0 idle, 1 capturing, 2 frozen.
  logic [26:0] m_q[$];
  int          m_mode = 0;
  logic        m_wrapped = 1'b0;
  logic [26:0] m_last = '0;

  trace_capture_buffer #(.DEPTH(DEPTH), .AW(AW), .HALT_IR(HALT)) dut (
    .Clk(Clk), .Reset(Reset), .Arm(Arm), .Cap_Valid(Cap_Valid),
    .PC_In(PC_In), .IR_In(IR_In), .State_In(State_In), .Rd_Req(Rd_Req),
    .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Count(Count),
    .Busy(Busy), .Done(Done), .Wrapped(Wrapped)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_v);
    chk(tag, "rd_valid", 32'(Rd_Valid), 32'(exp_v));
    chk(tag, "rd_data",  32'(Rd_Data),  32'(m_last));
    chk(tag, "count",    32'(Count),    32'(m_q.size()));
    chk(tag, "busy",     32'(Busy),     32'(m_mode == 1));
    chk(tag, "done",     32'(Done),     32'(m_mode == 2));
    chk(tag, "wrapped",  32'(Wrapped),  32'(m_wrapped));
  endtask

  // One clock: drive inputs, advance, update the model, compare every output.
  task automatic step(input logic arm, input logic cv, input logic [6:0] pc,
                      input logic [15:0] ir, input logic [3:0] st,
                      input logic rq, input string tag);
    logic exp_v;
    Arm = arm; Cap_Valid = cv; PC_In = pc; IR_In = ir; State_In = st; Rd_Req = rq;
    @(posedge Clk); #1;
    Arm = 1'b0; Cap_Valid = 1'b0; Rd_Req = 1'b0;
    exp_v = 1'b0;
    if (arm) begin
      m_q.delete();
      m_wrapped = 1'b0;
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (cv) begin
        m_q.push_back({st, pc, ir});
        if (m_q.size() > DEPTH) begin
          void'(m_q.pop_front());
          m_wrapped = 1'b1;
        end
        if (ir == HALT) m_mode = 2;
      end
    end else if (m_mode == 2) begin
      if (rq && m_q.size() > 0) begin
        m_last = m_q.pop_front();
        exp_v = 1'b1;
      end
    end
    chk_all(tag, exp_v);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2 Reset = 1'b1;
    #1;
    m_q.delete();
    m_mode = 0;
    m_wrapped = 1'b0;
    m_last = '0;
    chk_all(tag, 1'b0);
    #1 Reset = 1'b0;
  endtask

  initial begin
    logic [15:0] ir;
    int n;

    // Power-on reset, then async reset mid-cycle.
    @(posedge Clk); #1;
    Reset = 1'b0;
    do_reset("por");

    // Idle: captures and reads are ignored.
    step(0, 1, 7'h11, 16'h1111, 4'h1, 0, "idle_cap");
    step(0, 1, 7'h12, HALT,     4'h2, 1, "idle_cap_rd");
    chk("idle", "count_zero", 32'(Count), 0);

    // Basic capture of three instructions plus halt.
    step(1, 0, 0, 0, 0, 0, "arm");
    step(0, 0, 0, 0, 0, 1, "cap_rd_ignored");
    step(0, 1, 7'h00, 16'h1234, 4'h3, 0, "cap0");
    step(0, 1, 7'h01, 16'h2345, 4'h4, 0, "cap1");
    step(0, 1, 7'h02, 16'h3456, 4'h5, 0, "cap2");
    step(0, 1, 7'h03, HALT,     4'h6, 0, "cap_halt");
    chk("basic", "done",    32'(Done),    1);
    chk("basic", "count",   32'(Count),   4);
    chk("basic", "wrapped", 32'(Wrapped), 0);
    step(0, 1, 7'h04, 16'h7777, 4'h7, 0, "done_cap_ignored");
    step(0, 0, 0, 0, 0, 1, "basic_rd0");
    chk("basic", "ir0", 32'(Rd_Data), 32'({4'h3, 7'h00, 16'h1234}));
    step(0, 0, 0, 0, 0, 1, "basic_rd1");
    chk("basic", "ir1", 32'(Rd_Data[15:0]), 32'h2345);
    step(0, 0, 0, 0, 0, 1, "basic_rd2");
    chk("basic", "ir2", 32'(Rd_Data[15:0]), 32'h3456);
    step(0, 0, 0, 0, 0, 1, "basic_rd3");
    chk("basic", "ir3", 32'(Rd_Data), 32'({4'h6, 7'h03, 16'h5000}));
    chk("basic", "count_end", 32'(Count), 0);
    step(0, 0, 0, 0, 0, 1, "empty_rd");
    chk("empty", "valid", 32'(Rd_Valid), 0);
    step(0, 0, 0, 0, 0, 0, "hold");

    // Wrap-around: 20 captures and a halt leave PC 5..20.
    step(1, 0, 0, 0, 0, 0, "wrap_arm");
    for (int i = 0; i < 20; i++)
      step(0, 1, 7'(i), 16'(16'h0100 + i), 4'(i), 0, "wrap_cap");
    step(0, 1, 7'd20, HALT, 4'h9, 0, "wrap_halt");
    chk("wrap", "count",   32'(Count),   16);
    chk("wrap", "wrapped", 32'(Wrapped), 1);
    step(0, 0, 0, 0, 0, 1, "wrap_rd_first");
    chk("wrap", "first_pc", 32'(Rd_Data[22:16]), 5);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 0, 1, "wrap_rd_burst");
    step(0, 0, 0, 0, 0, 1, "wrap_rd_last");
    chk("wrap", "last_pc", 32'(Rd_Data[22:16]), 20);
    chk("wrap", "last_ir", 32'(Rd_Data[15:0]), 32'h5000);

    // Arm and Cap_Valid together in DONE with four entries: Arm wins.
    step(1, 0, 0, 0, 0, 0, "sim_arm");
    for (int i = 0; i < 3; i++) step(0, 1, 7'(i + 40), 16'(i + 16'h0a00), 4'h1, 0, "sim_cap");
    step(0, 1, 7'd43, HALT, 4'h1, 0, "sim_halt");
    chk("sim", "count4", 32'(Count), 4);
    step(1, 1, 7'h55, 16'h4444, 4'h2, 1, "sim_arm_cap");
    chk("sim", "busy",  32'(Busy),  1);
    chk("sim", "count", 32'(Count), 0);
    step(0, 1, 7'h56, HALT, 4'h3, 0, "sim_halt2");
    chk("sim", "count1", 32'(Count), 1);

    // Reset mid-capture, then a fresh short capture.
    step(1, 0, 0, 0, 0, 0, "rst_arm");
    for (int i = 0; i < 5; i++) step(0, 1, 7'(i + 60), 16'(i + 16'h0b00), 4'h4, 0, "rst_cap");
    do_reset("mid_rst");
    step(1, 0, 0, 0, 0, 0, "rst_rearm");
    step(0, 1, 7'h70, 16'hc001, 4'h8, 0, "rst_cap_a");
    step(0, 1, 7'h71, 16'hc002, 4'h9, 0, "rst_cap_b");
    step(0, 1, 7'h72, HALT,     4'ha, 0, "rst_halt");
    chk("rst", "count3", 32'(Count), 3);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, "rst_rd");

    // Randomized sessions with idle gaps, stray reads and stray captures.
    for (int it = 0; it < 8; it++) begin
      step(1, 1'($urandom), 7'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), "rnd_arm");
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) begin
        ir = 16'($urandom);
        if (ir == HALT) ir = 16'h5001;
        step(0, 1'($urandom_range(0, 3) != 0), 7'($urandom), ir, 4'($urandom),
             1'($urandom), "rnd_cap");
      end
      step(0, 1, 7'($urandom), HALT, 4'($urandom), 0, "rnd_halt");
      for (int k = 0; k < 2 * DEPTH + 4; k++)
        step(0, 1'($urandom), 7'($urandom), 16'($urandom), 4'($urandom),
             1'($urandom_range(0, 3) != 0), "rnd_rd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
